// File: rtl/seq_priority_encoder_if.sv
// rtl/seq_priority_encoder_if.sv - request/index handshake bundle for seq_priority_encoder
//
// Purpose: groups the input-vector handshake, the index-output handshake and
//          the status flags of seq_priority_encoder into one interface.
// Parameters:
//   N      width of the request vector
//   IDX_W  width of the emitted index
// Signals:
//   in_vec     request vector (source -> encoder)
//   in_valid   in_vec is valid (source -> encoder)
//   in_ready   encoder can accept a vector (encoder -> source)
//   out_idx    index of the currently selected bit (encoder -> consumer)
//   out_valid  out_idx is valid (encoder -> consumer)
//   out_ready  consumer accepts out_idx (consumer -> encoder)
//   out_last   out_idx is the final index of the vector (encoder -> consumer)
//   zero_in    one-cycle pulse, an all-zero vector was accepted
//   busy       encoder is draining a vector
// Modports:
//   master  the source/consumer side (drives in_*, out_ready)
//   slave   the encoder side

interface seq_priority_encoder_if #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) ();

   logic [N-1:0]     in_vec;
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] out_idx;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic             zero_in;
   logic             busy;

   modport master (
      output in_vec,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  out_idx,
      input  out_valid,
      input  out_last,
      input  zero_in,
      input  busy
   );

   modport slave (
      input  in_vec,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output out_idx,
      output out_valid,
      output out_last,
      output zero_in,
      output busy
   );

endinterface

// File: rtl/seq_priority_encoder.sv
// rtl/seq_priority_encoder.sv - sequential priority encoder, one index per handshake
//
// Purpose: captures an N-bit request vector on an input handshake and emits
//          the binary index of every set bit, one per output handshake,
//          then returns to IDLE after the last index.
// Configuration macro:
//   SEQ_PRIO_MSB_FIRST_EN  defined: highest set bit first (descending order)
//                          undefined: lowest set bit first (ascending order)
// Parameters:
//   N      request vector width, 2..64
//   IDX_W  index width, must equal $clog2(N)
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   bus    seq_priority_encoder_if.slave
//          in_vec/in_valid/in_ready   vector input handshake
//          out_idx/out_valid/out_ready/out_last  index output handshake
//          zero_in  one-cycle pulse after an all-zero vector is accepted
//          busy     high while draining a vector

module seq_priority_encoder #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   seq_priority_encoder_if.slave  bus
);

   // Elaboration-time parameter checks.
   generate
      if (N < 2 || N > 64) begin : g_bad_n
         $error("seq_priority_encoder: N=%0d outside 2..64", N);
      end
      if (IDX_W != $clog2(N)) begin : g_bad_idx_w
         $error("seq_priority_encoder: IDX_W=%0d must be $clog2(N)=%0d", IDX_W, $clog2(N));
      end
   endgenerate

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [N-1:0]     pending_q;
   logic [N-1:0]     pending_d;
   logic             zero_q;
   logic             zero_d;

   logic [IDX_W-1:0] sel_idx;
   logic [N-1:0]     sel_mask;
   logic             sel_single;
   logic             in_fire;
   logic             out_fire;

   // Pick the next bit of pending. The loop runs toward the preferred end so
   // the last hit (the preferred bit) wins; sel_mask is its one-hot.
   always_comb begin
      sel_idx  = '0;
      sel_mask = '0;
`ifdef SEQ_PRIO_MSB_FIRST_EN
      for (int i = 0; i < N; i++) begin
         if (pending_q[i]) begin
            sel_idx     = IDX_W'(i);
            sel_mask    = '0;
            sel_mask[i] = 1'b1;
         end
      end
`else
      for (int i = N - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_idx     = IDX_W'(i);
            sel_mask    = '0;
            sel_mask[i] = 1'b1;
         end
      end
`endif
   end

   // Exactly one bit left: nothing remains once the selected bit is removed.
   assign sel_single = (pending_q != '0) && ((pending_q & ~sel_mask) == '0);

   assign in_fire  = bus.in_valid  && (state_q == IDLE);
   assign out_fire = bus.out_ready && (state_q == DRAIN);

   // Next-state and pending update.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      zero_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_fire) begin
               if (bus.in_vec == '0) begin
                  zero_d = 1'b1;
               end else begin
                  pending_d = bus.in_vec;
                  state_d   = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pending_q == '0) begin
               // Unreachable in normal operation; never stall in DRAIN
               // with nothing to emit.
               state_d = IDLE;
            end else if (out_fire) begin
               pending_d = pending_q & ~sel_mask;
               if (sel_single) begin
                  state_d   = IDLE;
                  pending_d = '0;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         zero_q    <= zero_d;
      end
   end

   // Outputs depend only on state_q, pending_q and zero_q, so there is no
   // combinational path from the input handshake to the output side.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DRAIN);
   assign bus.busy      = (state_q == DRAIN);
   assign bus.out_idx   = (state_q == DRAIN) ? sel_idx : '0;
   assign bus.out_last  = (state_q == DRAIN) && sel_single;
   assign bus.zero_in   = zero_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// tb/tb_seq_priority_encoder.sv - directed self-checking bench for seq_priority_encoder

module tb_seq_priority_encoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seq_priority_encoder_if #(.N(8),  .IDX_W(3)) b8 ();
   seq_priority_encoder_if #(.N(16), .IDX_W(4)) b16 ();

   seq_priority_encoder #(.N(8), .IDX_W(3)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (b8)
   );

   seq_priority_encoder #(.N(16), .IDX_W(4)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (b16)
   );

   // Observed tuple: {in_ready, out_valid, out_idx, out_last, zero_in, busy}
   logic [7:0] obs8;
   logic [8:0] obs16;
   assign obs8  = {b8.in_ready, b8.out_valid, b8.out_idx, b8.out_last, b8.zero_in, b8.busy};
   assign obs16 = {b16.in_ready, b16.out_valid, b16.out_idx, b16.out_last, b16.zero_in, b16.busy};

   function automatic logic [7:0] st_idle(input logic z);
      return {1'b1, 1'b0, 3'd0, 1'b0, z, 1'b0};
   endfunction

   function automatic logic [7:0] st_drain(input int idx, input logic last);
      return {1'b0, 1'b1, 3'(idx), last, 1'b0, 1'b1};
   endfunction

   function automatic logic [8:0] st16_drain(input int idx, input logic last);
      return {1'b0, 1'b1, 4'(idx), last, 1'b0, 1'b1};
   endfunction

   task automatic test_reset;
      b8.in_vec = '0;  b8.in_valid = 1'b0;  b8.out_ready = 1'b1;
      b16.in_vec = '0; b16.in_valid = 1'b0; b16.out_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs8 !== st_idle(1'b0)) begin
         errors++; $display("FAIL reset_n8: observed %b expected %b", obs8, st_idle(1'b0));
      end
      checks++;
      if (obs16 !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset_n16: observed %b expected %b", obs16, 9'b100000000);
      end
      rst = 1'b0;
   endtask

   task automatic test_single;
      b8.in_vec = 8'b0000_0001; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (obs8 !== st_drain(0, 1'b1)) begin
         errors++; $display("FAIL single_idx: observed %b expected %b", obs8, st_drain(0, 1'b1));
      end
      b8.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (obs8 !== st_idle(1'b0)) begin
         errors++; $display("FAIL single_ready: observed %b expected %b", obs8, st_idle(1'b0));
      end
   endtask

   task automatic test_three_bits;
      int seq[3];
`ifdef SEQ_PRIO_MSB_FIRST_EN
      seq = '{7, 5, 2};
`else
      seq = '{2, 5, 7};
`endif
      b8.in_vec = 8'b1010_0100; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         b8.in_valid = 1'b0;
         checks++;
         if (obs8 !== st_drain(seq[k], k == 2)) begin
            errors++; $display("FAIL three_bits[%0d]: observed %b expected %b", k, obs8, st_drain(seq[k], k == 2));
         end
      end
      @(negedge clk);
      checks++;
      if (obs8 !== st_idle(1'b0)) begin
         errors++; $display("FAIL three_bits_end: observed %b expected %b", obs8, st_idle(1'b0));
      end
   endtask

   task automatic test_backpressure;
      int seq[3];
`ifdef SEQ_PRIO_MSB_FIRST_EN
      seq = '{7, 5, 2};
`else
      seq = '{2, 5, 7};
`endif
      b8.in_vec = 8'b1010_0100; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         b8.in_valid = 1'b0;
         b8.in_vec   = 8'hFF;
         checks++;
         if (obs8 !== st_drain(seq[0], 1'b0)) begin
            errors++; $display("FAIL bp_hold[%0d]: observed %b expected %b", k, obs8, st_drain(seq[0], 1'b0));
         end
      end
      b8.out_ready = 1'b1;
      for (int k = 1; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (obs8 !== st_drain(seq[k], k == 2)) begin
            errors++; $display("FAIL bp_release[%0d]: observed %b expected %b", k, obs8, st_drain(seq[k], k == 2));
         end
      end
      @(negedge clk);
      checks++;
      if (obs8 !== st_idle(1'b0)) begin
         errors++; $display("FAIL bp_end: observed %b expected %b", obs8, st_idle(1'b0));
      end
   endtask

   task automatic test_zero;
      b8.in_vec = 8'h00; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
      @(negedge clk);
      b8.in_valid = 1'b0;
      checks++;
      if (obs8 !== st_idle(1'b1)) begin
         errors++; $display("FAIL zero_pulse: observed %b expected %b", obs8, st_idle(1'b1));
      end
      @(negedge clk);
      checks++;
      if (obs8 !== st_idle(1'b0)) begin
         errors++; $display("FAIL zero_clear: observed %b expected %b", obs8, st_idle(1'b0));
      end
   endtask

   task automatic test_full;
      int exp_idx;
      b8.in_vec = 8'hFF; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         b8.in_valid = 1'b0;
`ifdef SEQ_PRIO_MSB_FIRST_EN
         exp_idx = 7 - k;
`else
         exp_idx = k;
`endif
         checks++;
         if (obs8 !== st_drain(exp_idx, k == 7)) begin
            errors++; $display("FAIL full[%0d]: observed %b expected %b", k, obs8, st_drain(exp_idx, k == 7));
         end
      end
      @(negedge clk);
      checks++;
      if (obs8 !== st_idle(1'b0)) begin
         errors++; $display("FAIL full_end: observed %b expected %b", obs8, st_idle(1'b0));
      end
   endtask

   task automatic test_reset_mid_drain;
      int ord[5];
`ifdef SEQ_PRIO_MSB_FIRST_EN
      ord = '{7, 6, 5, 4, 3};
`else
      ord = '{0, 1, 2, 3, 4};
`endif
      b8.in_vec = 8'hFF; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         b8.in_valid = 1'b0;
         checks++;
         if (obs8 !== st_drain(ord[k], 1'b0)) begin
            errors++; $display("FAIL rst_mid_pre[%0d]: observed %b expected %b", k, obs8, st_drain(ord[k], 1'b0));
         end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (obs8 !== st_idle(1'b0)) begin
         errors++; $display("FAIL rst_mid_idle: observed %b expected %b", obs8, st_idle(1'b0));
      end
      b8.in_vec = 8'h10; b8.in_valid = 1'b1;
      @(negedge clk);
      b8.in_valid = 1'b0;
      checks++;
      if (obs8 !== st_drain(4, 1'b1)) begin
         errors++; $display("FAIL rst_mid_new: observed %b expected %b", obs8, st_drain(4, 1'b1));
      end
      @(negedge clk);
      checks++;
      if (obs8 !== st_idle(1'b0)) begin
         errors++; $display("FAIL rst_mid_end: observed %b expected %b", obs8, st_idle(1'b0));
      end
   endtask

   task automatic test_back_to_back;
      int ord[2];
`ifdef SEQ_PRIO_MSB_FIRST_EN
      ord = '{1, 0};
`else
      ord = '{0, 1};
`endif
      b8.in_vec = 8'h03; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
      @(negedge clk);
      b8.in_vec = 8'h80;    // presented while busy, must wait for in_ready
      checks++;
      if (obs8 !== st_drain(ord[0], 1'b0)) begin
         errors++; $display("FAIL b2b_a0: observed %b expected %b", obs8, st_drain(ord[0], 1'b0));
      end
      @(negedge clk);
      checks++;
      if (obs8 !== st_drain(ord[1], 1'b1)) begin
         errors++; $display("FAIL b2b_a1: observed %b expected %b", obs8, st_drain(ord[1], 1'b1));
      end
      @(negedge clk);
      checks++;
      if (obs8 !== st_idle(1'b0)) begin
         errors++; $display("FAIL b2b_bubble: observed %b expected %b", obs8, st_idle(1'b0));
      end
      @(negedge clk);
      b8.in_valid = 1'b0;
      checks++;
      if (obs8 !== st_drain(7, 1'b1)) begin
         errors++; $display("FAIL b2b_b: observed %b expected %b", obs8, st_drain(7, 1'b1));
      end
      @(negedge clk);
      checks++;
      if (obs8 !== st_idle(1'b0)) begin
         errors++; $display("FAIL b2b_end: observed %b expected %b", obs8, st_idle(1'b0));
      end
   endtask

   task automatic test_n16;
      int ord[2];
`ifdef SEQ_PRIO_MSB_FIRST_EN
      ord = '{15, 0};
`else
      ord = '{0, 15};
`endif
      b16.in_vec = 16'h8001; b16.in_valid = 1'b1; b16.out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         b16.in_valid = 1'b0;
         checks++;
         if (obs16 !== st16_drain(ord[k], k == 1)) begin
            errors++; $display("FAIL n16[%0d]: observed %b expected %b", k, obs16, st16_drain(ord[k], k == 1));
         end
      end
      @(negedge clk);
      checks++;
      if (obs16 !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL n16_end: observed %b expected %b", obs16, 9'b100000000);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_three_bits;
      test_backpressure;
      test_zero;
      test_full;
      test_reset_mid_drain;
      test_back_to_back;
      test_n16;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
